seq_cmp_nib: RTL

SEQ_CMP_NIB -- requirements
Module: seq_cmp_nib

---
 rtl/seq_cmp_pkg.sv | 26 ++
 rtl/seq_cmp_nib_cmp.sv | 21 ++
 rtl/seq_cmp_nib.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/seq_cmp_pkg.sv
// seq_cmp_pkg -- shared definitions for the sequential nibble comparator.
//   * FSM state encoding (IDLE, CMP, DONE)
//   * NIB_W: width of one compared slice (a nibble)
//   * result encoding res_e and a helper turning a result into {lt, eq, gt}
package seq_cmp_pkg;

  localparam int NIB_W = 4;

  // FSM states
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMP  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Result of comparing A against B
  typedef enum logic [1:0] {
    RES_EQ = 2'd0,
    RES_LT = 2'd1,
    RES_GT = 2'd2
  } res_e;

  // Expand a result code into the {lt, eq, gt} output flags
  function automatic logic [2:0] res_flags(input res_e r);
    return {r == RES_LT, r == RES_EQ, r == RES_GT};
  endfunction

endpackage

// File: rtl/seq_cmp_nib_cmp.sv
// nib_cmp -- purely combinational unsigned compare of two nibbles.
// Ports:
//   a_i, b_i : 4-bit operands
//   lt_o     : a_i <  b_i
//   eq_o     : a_i == b_i
//   gt_o     : a_i >  b_i
module nib_cmp
  import seq_cmp_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  output logic             lt_o,
  output logic             eq_o,
  output logic             gt_o
);

  assign lt_o = (a_i <  b_i);
  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i >  b_i);

endmodule

// File: rtl/seq_cmp_nib.sv
// seq_cmp_nib -- sequential comparator that walks two W = 4*NIB bit operands
// one nibble per cycle, most significant nibble first, through a single shared
// nib_cmp instance. Supports unsigned and two's-complement ordering.
//
// Parameters:
//   NIB   : operand width in nibbles (1..8)
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   start : begin a compare (sampled in IDLE only), latches a, b, sgn
//   a, b  : operands
//   sgn   : 1 = two's-complement compare, 0 = unsigned
//   busy  : high during every CMP cycle
//   done  : one-cycle pulse when lt/eq/gt carry a new result
//   lt, eq, gt : registered compare result, held until the next completion
//
// Build option: define SEQ_CMP_EARLY_EXIT_EN to stop at the first differing
// nibble. Without it, every compare takes exactly NIB cycles and the first
// differing nibble's result is kept in a sticky register until idx reaches 0.
module seq_cmp_nib
  import seq_cmp_pkg::*;
#(
  parameter int NIB = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [4*NIB-1:0]   a,
  input  logic [4*NIB-1:0]   b,
  input  logic               sgn,
  output logic               busy,
  output logic               done,
  output logic               lt,
  output logic               eq,
  output logic               gt
);

  localparam int W     = NIB_W * NIB;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(NIB - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [W-1:0]     a_q,     a_d;
  logic [W-1:0]     b_q,     b_d;
  logic             sgn_q,   sgn_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             lt_q,    lt_d;
  logic             eq_q,    eq_d;
  logic             gt_q,    gt_d;

  // Current nibble pair, with the sign bit flipped on the top nibble of a
  // signed compare so that plain unsigned ordering gives two's-complement order.
  logic [NIB_W-1:0] nib_a, nib_b;
  logic             flip_msb;
  logic             n_lt, n_eq, n_gt;
  res_e             nib_res;
  res_e             final_res;
  logic             decided;

  assign flip_msb = sgn_q && (idx_q == IDX_MSB);
  assign nib_a    = a_q[idx_q*NIB_W +: NIB_W] ^ {flip_msb, 3'b000};
  assign nib_b    = b_q[idx_q*NIB_W +: NIB_W] ^ {flip_msb, 3'b000};

  nib_cmp u_nib_cmp (
    .a_i  (nib_a),
    .b_i  (nib_b),
    .lt_o (n_lt),
    .eq_o (n_eq),
    .gt_o (n_gt)
  );

  assign nib_res = n_lt ? RES_LT : (n_gt ? RES_GT : RES_EQ);

`ifdef SEQ_CMP_EARLY_EXIT_EN
  // Any differing nibble settles the order; only all-equal needs idx=0.
  assign decided   = (idx_q == '0) || !n_eq;
  assign final_res = nib_res;
`else
  // Fixed-latency walk: remember the first non-EQ nibble and report at idx=0.
  res_e sticky_q, sticky_d;

  assign decided   = (idx_q == '0);
  assign final_res = (sticky_q != RES_EQ) ? sticky_q : nib_res;

  always_comb begin
    sticky_d = sticky_q;
    if (state_q == IDLE && start) begin
      sticky_d = RES_EQ;
    end else if (state_q == CMP && sticky_q == RES_EQ) begin
      sticky_d = nib_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= RES_EQ;
    end else begin
      sticky_q <= sticky_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sgn_d   = sgn;
          idx_d   = IDX_MSB;
          busy_d  = 1'b1;
          state_d = CMP;
        end
      end
      CMP: begin
        if (decided) begin
          {lt_d, eq_d, gt_d} = res_flags(final_res);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign lt   = lt_q;
  assign eq   = eq_q;
  assign gt   = gt_q;

endmodule
